// File: rtl/crossbar_4x4_rr_scheduler.sv
// crossbar_4x4_rr_scheduler
//   Scheduler for a 4x4 crossbar. Each output owns a small IDLE/LOCKED FSM
//   with a round-robin pointer. An output locks to one input for a whole
//   packet and drives that input's ready line and the crossbar source select.
//   Optional build macro CROSSBAR_SCHED_STATS_EN adds saturating per-output
//   grant counters on the grant_cnt port.
//   Only NUM_PORTS = 4 is supported (2-bit selects).

module crossbar_4x4_rr_scheduler #(
  parameter int NUM_PORTS    = 4,
  parameter int LOCK_TIMEOUT = 0,
  parameter int CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS-1:0]     in_valid,
  input  logic [2*NUM_PORTS-1:0]   in_dest,
  input  logic [NUM_PORTS-1:0]     in_last,
  output logic [NUM_PORTS-1:0]     in_ready,
  output logic [2*NUM_PORTS-1:0]   out_sel,
  output logic [NUM_PORTS-1:0]     out_en,
  output logic [NUM_PORTS-1:0]     out_valid
`ifdef CROSSBAR_SCHED_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0] grant_cnt
`endif
);

  localparam int SEL_W = 2;

  // Per-output FSM encoding.
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // Idle-cycle counter sized to hold LOCK_TIMEOUT-1.
  localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  // Per-output state.
  logic [NUM_PORTS-1:0] r_state;
  logic [SEL_W-1:0]     r_owner [NUM_PORTS];
  logic [SEL_W-1:0]     r_ptr   [NUM_PORTS];
  logic [TMO_W-1:0]     r_tmo   [NUM_PORTS];

  // Combinational helpers.
  logic [NUM_PORTS-1:0] w_busy;
  logic [NUM_PORTS-1:0] w_cand [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_found;
  logic [SEL_W-1:0]     w_win  [NUM_PORTS];
  logic [SEL_W-1:0]     w_scan;
  logic [NUM_PORTS-1:0] w_xfer;
  logic [NUM_PORTS-1:0] w_done;
  logic [NUM_PORTS-1:0] w_tmo_hit;

  // Mark inputs that currently own an output; they get ready and are barred
  // from competing for any other output.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // write, otherwise the tool infers a latch to hold the old value.
    w_busy = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (r_state[j] == ST_LOCKED) w_busy[r_owner[j]] = 1'b1;
    end
  end

  // Build each output's candidate set from live requests of free inputs.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_cand[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_cand[j][i] = in_valid[i] && !w_busy[i] &&
                       (in_dest[SEL_W*i +: SEL_W] == SEL_W'(j));
      end
    end
  end

  // Round-robin pick: first candidate scanning ptr, ptr+1, ... modulo 4.
  always_comb begin
    w_scan = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_found[j] = 1'b0;
      w_win[j]   = r_ptr[j];
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_scan = r_ptr[j] + SEL_W'(k);
        if (!w_found[j] && w_cand[j][w_scan]) begin
          w_found[j] = 1'b1;
          w_win[j]   = w_scan;
        end
      end
    end
  end

  // Transfer, end-of-packet and idle-timeout conditions of locked outputs.
  always_comb begin
    w_xfer    = '0;
    w_done    = '0;
    w_tmo_hit = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_xfer[j]    = (r_state[j] == ST_LOCKED) && in_valid[r_owner[j]];
      w_done[j]    = w_xfer[j] && in_last[r_owner[j]];
      w_tmo_hit[j] = (LOCK_TIMEOUT > 0) && (r_state[j] == ST_LOCKED) &&
                     !w_xfer[j] && (r_tmo[j] == TMO_MAX);
    end
  end

  // Per-output FSM: grant on IDLE, release on last beat or idle timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        // NOTE: sequential state is written with <= so every flop samples the
        // pre-edge values of the others, independent of statement order.
        r_state[j] <= ST_IDLE;
        r_owner[j] <= '0;
        r_ptr[j]   <= '0;
        r_tmo[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (r_state[j] == ST_IDLE) begin
          if (w_found[j]) begin
            r_state[j] <= ST_LOCKED;
            r_owner[j] <= w_win[j];
            r_ptr[j]   <= w_win[j] + SEL_W'(1);
            r_tmo[j]   <= '0;
          end
        end else if (w_done[j]) begin
          // Owner is kept so the crossbar select holds its last value.
          r_state[j] <= ST_IDLE;
          r_tmo[j]   <= '0;
        end else if (w_xfer[j]) begin
          r_tmo[j] <= '0;
        end else if (LOCK_TIMEOUT > 0) begin
          // Forced release leaves the round-robin pointer where it was.
          if (w_tmo_hit[j]) begin
            r_state[j] <= ST_IDLE;
            r_tmo[j]   <= '0;
          end else begin
            r_tmo[j] <= r_tmo[j] + TMO_W'(1);
          end
        end
      end
    end
  end

  // Drive handshake and crossbar controls from the registered lock state.
  always_comb begin
    out_sel = '0;
    out_en  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      out_sel[SEL_W*j +: SEL_W] = r_owner[j];
      out_en[j]                 = (r_state[j] == ST_LOCKED);
    end
  end

  assign in_ready  = w_busy;
  assign out_valid = w_xfer;

`ifdef CROSSBAR_SCHED_STATS_EN
  logic [CNT_W-1:0] r_cnt [NUM_PORTS];

  // Count IDLE->LOCKED transitions per output, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_PORTS; j++) r_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if ((r_state[j] == ST_IDLE) && w_found[j] && (r_cnt[j] != '1)) begin
          r_cnt[j] <= r_cnt[j] + CNT_W'(1);
        end
      end
    end
  end

  // Pack the counters onto the flat statistics port.
  always_comb begin
    grant_cnt = '0;
    for (int j = 0; j < NUM_PORTS; j++) grant_cnt[CNT_W*j +: CNT_W] = r_cnt[j];
  end
`endif

endmodule

// File: tb/tb_crossbar_4x4_rr_scheduler.sv
// Bench for crossbar_4x4_rr_scheduler. Expected grants ({output, source})
// are queued as packets are loaded and popped when out_en rises. A second
// instance with LOCK_TIMEOUT=4 covers forced release.

module tb_crossbar_4x4_rr_scheduler;

  localparam int TB_CNT_W = 2;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [7:0] in_dest;
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic [7:0] out_sel;
  logic [3:0] out_en;
  logic [3:0] out_valid;
  logic [3:0] tmo_ready;
  logic [7:0] tmo_sel;
  logic [3:0] tmo_en;
  logic [3:0] tmo_valid;
`ifdef CROSSBAR_SCHED_STATS_EN
  logic [4*TB_CNT_W-1:0] grant_cnt;
  logic [31:0]           tmo_cnt;
`endif

  crossbar_4x4_rr_scheduler #(.NUM_PORTS(4), .LOCK_TIMEOUT(0), .CNT_W(TB_CNT_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sel   (out_sel),
    .out_en    (out_en),
    .out_valid (out_valid)
`ifdef CROSSBAR_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  crossbar_4x4_rr_scheduler #(.NUM_PORTS(4), .LOCK_TIMEOUT(4), .CNT_W(8)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_ready  (tmo_ready),
    .out_sel   (tmo_sel),
    .out_en    (tmo_en),
    .out_valid (tmo_valid)
`ifdef CROSSBAR_SCHED_STATS_EN
    ,
    .grant_cnt (tmo_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Source model state per input.
  int         pkts_left  [4];
  int         beats_left [4];
  int         pkt_len    [4];
  logic [1:0] cur_dest   [4];
  int         acc_cnt    [4];
  logic [3:0] hold;

  // Scoreboard of expected grants and observation samples.
  logic [3:0] sb_q [$];
  int         gt2 [$];
  logic [3:0] prev_en;
  logic [3:0] en_seen;
  logic [3:0] s_en, s_valid, s_ready, s_tmo_en;
  logic [7:0] s_sel, s_tmo_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_grant(input logic [1:0] out_j, input logic [1:0] src);
    sb_q.push_back({out_j, src});
  endtask

  task automatic load(input int i, input logic [1:0] dest, input int len, input int n);
    cur_dest[i]   = dest;
    pkt_len[i]    = len;
    beats_left[i] = len;
    pkts_left[i]  = n;
    acc_cnt[i]    = 0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid[i]       = (pkts_left[i] > 0) && !hold[i];
      in_dest[2*i +: 2] = cur_dest[i];
      in_last[i]        = (pkts_left[i] > 0) && !hold[i] && (beats_left[i] == 1);
    end
  endtask

  // One clock cycle: drive, sample at negedge, score grants, advance sources.
  task automatic cycle();
    logic [3:0] acc;
    logic [3:0] obs;
    apply_inputs();
    @(negedge clk);
    s_en      = out_en;
    s_valid   = out_valid;
    s_ready   = in_ready;
    s_sel     = out_sel;
    s_tmo_en  = tmo_en;
    s_tmo_sel = tmo_sel;
    en_seen   = en_seen | s_en;
    acc       = in_valid & in_ready;
    for (int j = 0; j < 4; j++) begin
      if (s_en[j] && !prev_en[j]) begin
        obs = {2'(j), s_sel[2*j +: 2]};
        if (sb_q.size() == 0) check("grant_unexpected", {28'd0, obs}, 32'hFFFF_FFFF);
        else check("grant", {28'd0, obs}, {28'd0, sb_q.pop_front()});
        if (j == 2) gt2.push_back(cyc);
      end
    end
    prev_en = s_en;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        acc_cnt[i]++;
        if (beats_left[i] == 1) begin
          pkts_left[i]--;
          beats_left[i] = pkt_len[i];
        end else begin
          beats_left[i]--;
        end
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    logic [3:0] pend;
    pend = 4'hF;
    while (pend != 0 && n < budget) begin
      cycle();
      n++;
      for (int i = 0; i < 4; i++) pend[i] = (pkts_left[i] > 0);
    end
    check("drain_timeout", {28'd0, pend}, 32'd0);
  endtask

  // Two reset cycles with random inputs, then check the cleared outputs.
  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) begin
      in_valid = 4'($urandom);
      in_dest  = 8'($urandom);
      in_last  = 4'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("rst_in_ready", {28'd0, in_ready}, 32'd0);
    check("rst_out_en",   {28'd0, out_en},   32'd0);
    check("rst_out_sel",  {24'd0, out_sel},  32'd0);
    check("rst_tmo_en",   {28'd0, tmo_en},   32'd0);
    rst      = 1'b0;
    in_valid = '0;
    in_last  = '0;
    for (int i = 0; i < 4; i++) load(i, 2'd0, 1, 0);
    hold    = '0;
    prev_en = '0;
    en_seen = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_dest  = '0;
    in_last  = '0;
    hold     = '0;
    prev_en  = '0;
    en_seen  = '0;
    for (int i = 0; i < 4; i++) load(i, 2'd0, 1, 0);

    // Reset behaviour.
    reset_dut();

    // Four inputs contend for output 2 with 1-beat packets; input 0 sends two.
    load(0, 2'd2, 1, 2);
    load(1, 2'd2, 1, 1);
    load(2, 2'd2, 1, 1);
    load(3, 2'd2, 1, 1);
    push_grant(2'd2, 2'd0);
    push_grant(2'd2, 2'd1);
    push_grant(2'd2, 2'd2);
    push_grant(2'd2, 2'd3);
    push_grant(2'd2, 2'd0);
    gt2.delete();
    run_until_idle(40);
    cycle();
    check("rr_final_idle", {28'd0, s_en}, 32'd0);
    check("rr_grant_count", gt2.size(), 32'd5);
    for (int k = 1; k < gt2.size(); k++) check("rr_grant_gap", gt2[k] - gt2[k-1], 32'd2);
    check("rr_other_outputs_idle", {28'd0, en_seen & 4'b1011}, 32'd0);

    // Crossed 3-beat packets: in0->out1 and in1->out0 in the same cycle.
    reset_dut();
    load(0, 2'd1, 3, 1);
    load(1, 2'd0, 3, 1);
    push_grant(2'd0, 2'd1);
    push_grant(2'd1, 2'd0);
    cycle();
    check("x_req_no_en", {28'd0, s_en}, 32'd0);
    cycle();
    check("x_sel", {24'd0, s_sel}, 32'h01);
    check("x_en", {28'd0, s_en}, 32'h3);
    check("x_ready", {28'd0, s_ready}, 32'h3);
    cycle();
    cycle();
    cycle();
    check("x_idle", {28'd0, s_en}, 32'd0);
    check("x_beats_in0", acc_cnt[0], 32'd3);
    check("x_beats_in1", acc_cnt[1], 32'd3);

    // Reset in the middle of a packet drops the lock.
    load(2, 2'd0, 8, 1);
    push_grant(2'd0, 2'd2);
    cycle();
    cycle();
    cycle();
    check("mid_locked", {28'd0, s_en}, 32'h1);
    reset_dut();

    // in3 locked to out0 with a 2-cycle valid gap mid-packet.
    load(3, 2'd0, 4, 1);
    push_grant(2'd0, 2'd3);
    cycle();
    cycle();
    check("gap_first_valid", {28'd0, s_valid}, 32'h1);
    hold[3] = 1'b1;
    cycle();
    check("gap_valid_low", {28'd0, s_valid}, 32'd0);
    check("gap_lock_held", {28'd0, s_en}, 32'h1);
    check("gap_ready_held", {28'd0, s_ready}, 32'h8);
    cycle();
    check("gap_valid_low2", {28'd0, s_valid}, 32'd0);
    check("gap_lock_held2", {28'd0, s_en}, 32'h1);
    hold[3] = 1'b0;
    run_until_idle(20);
    cycle();
    check("gap_released", {28'd0, s_en}, 32'd0);
    check("gap_beats", acc_cnt[3], 32'd4);

    // Timeout instance: in1 locks out1 then goes silent.
    reset_dut();
    load(1, 2'd1, 4, 1);
    push_grant(2'd1, 2'd1);
    cycle();
    hold[1] = 1'b1;
    cycle();
    check("tmo_locked", {28'd0, s_tmo_en}, 32'h2);
    cycle();
    cycle();
    cycle();
    check("tmo_still_locked", {28'd0, s_tmo_en}, 32'h2);
    cycle();
    check("tmo_released", {28'd0, s_tmo_en}, 32'd0);
    check("tmo_main_held", {28'd0, s_en}, 32'h2);
    hold[1] = 1'b0;
    load(0, 2'd1, 4, 1);
    load(2, 2'd1, 4, 1);
    cycle();
    cycle();
    check("tmo_regrant_en", {28'd0, s_tmo_en}, 32'h2);
    check("tmo_ptr_kept", {30'd0, s_tmo_sel[3:2]}, 32'd2);

    // Five grants on output 3 for the statistics counter.
    reset_dut();
    load(0, 2'd3, 1, 5);
    for (int k = 0; k < 5; k++) push_grant(2'd3, 2'd0);
    run_until_idle(40);
    cycle();
    check("stat_beats", acc_cnt[0], 32'd5);
`ifdef CROSSBAR_SCHED_STATS_EN
    check("stat_cnt3_sat", {30'd0, grant_cnt[3*TB_CNT_W +: TB_CNT_W]}, 32'd3);
    check("stat_cnt0_zero", {30'd0, grant_cnt[0 +: TB_CNT_W]}, 32'd0);
`endif

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
